// File: rtl/exprom_ctrl.sv
// Expansion ROM controller: holds the Expansion ROM BAR, decodes PCI target memory
// requests and sequences reads, full writes and read-modify-write partial writes.
module exprom_ctrl #(
  parameter int ADDR_W   = 9,
  parameter int WRITABLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_be,
  input  logic [31:0]       cfg_wdata,
  output logic [31:0]       cfg_rdata,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [3:0]        req_be,
  input  logic [31:0]       req_wdata,
  output logic              hit,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_enable,
  output logic              rom_wren,
  output logic [31:0]       rom_dinp,
  input  logic [31:0]       rom_dout,
  output logic [2:0]        dbg_state
);

  localparam int          LO       = ADDR_W + 2;
  localparam logic [31:0] BAR_MASK = (32'hFFFF_FFFF << LO) | 32'h1;

  typedef enum logic [2:0] {IDLE, RD_CAP, RSP, RMW_MRG, RMW_WR} state_t;

  // Handshakes: a request transfers when req_valid, req_ready and hit are all high;
  // a response transfers when rsp_valid and rsp_ready are both high. rsp_valid and
  // rsp_data hold steady until the response transfers.

  state_t            state;
  logic [31:0]       bar_q;
  logic [31:0]       cfg_mask;
  logic [ADDR_W-1:0] word_addr;
  logic [ADDR_W-1:0] lat_addr;
  logic [3:0]        lat_be;
  logic [31:0]       lat_wdata;
  logic [31:0]       merge_q;
  logic              accept;
  logic              be_full;
  logic              be_part;
  logic              do_rd;
  logic              do_full;
  logic              do_rmw;
  logic              unused_addr_lsb;

  assign cfg_mask  = {{8{cfg_be[3]}}, {8{cfg_be[2]}}, {8{cfg_be[1]}}, {8{cfg_be[0]}}} & BAR_MASK;
  assign cfg_rdata = bar_q;
  assign hit       = bar_q[0] && (req_addr[31:LO] == bar_q[31:LO]);
  assign word_addr = req_addr[LO-1:2];
  assign unused_addr_lsb = ^req_addr[1:0];
  assign dbg_state = state;

  assign req_ready = rst_n && (state == IDLE) && !rsp_valid;
  assign accept    = req_valid && req_ready && hit;
  assign be_full   = (req_be == 4'hF);
  assign be_part   = (req_be != 4'h0) && !be_full;
  assign do_rd     = accept && !req_write;
  assign do_full   = accept && req_write && (WRITABLE != 0) && be_full;
  assign do_rmw    = accept && req_write && (WRITABLE != 0) && be_part;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_q <= '0;
    end else if (cfg_we) begin
      bar_q <= (bar_q & ~cfg_mask) | (cfg_wdata & cfg_mask);
    end
  end

  // ROM strobes are issued in the accept cycle so read data lands one cycle later.
  always_comb begin
    rom_enable  = 1'b0;
    rom_wren    = 1'b0;
    rom_address = '0;
    rom_dinp    = '0;
    if (state == RMW_WR) begin
      rom_enable  = 1'b1;
      rom_wren    = 1'b1;
      rom_address = lat_addr;
      rom_dinp    = merge_q;
    end else if (do_rd || do_rmw) begin
      rom_enable  = 1'b1;
      rom_address = word_addr;
    end else if (do_full) begin
      rom_enable  = 1'b1;
      rom_wren    = 1'b1;
      rom_address = word_addr;
      rom_dinp    = req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      lat_addr  <= '0;
      lat_be    <= '0;
      lat_wdata <= '0;
      merge_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (do_rd) begin
            state <= RD_CAP;
          end else if (do_rmw) begin
            lat_addr  <= word_addr;
            lat_be    <= req_be;
            lat_wdata <= req_wdata;
            state     <= RMW_MRG;
          end
        end
        RD_CAP: begin
          rsp_data  <= rom_dout;
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        RMW_MRG: begin
          for (int i = 0; i < 4; i++) begin
            merge_q[8*i +: 8] <= lat_be[i] ? lat_wdata[8*i +: 8] : rom_dout[8*i +: 8];
          end
          state <= RMW_WR;
        end
        RMW_WR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
